// File: rtl/memory_master.sv
// memory_master: single-access bus initiator between the datapath control
// unit and main memory. A request accepted in IDLE is presented to memory in
// ACCESS (address/write data held stable, RD or WRMain strobe high) until the
// memory acknowledges. COMPLETE then pulses Done for one cycle. When the
// optional timeout is built in, a missing ACK ends in ERROR, which pulses
// Error for one cycle.
//
// Optional feature macro: MEMORY_MASTER_TIMEOUT_EN
//   defined     -> 8-bit ACK timeout counter and ERROR state are present
//   not defined -> ACCESS waits for ACK forever, Error_Out is constant 0
//
// Ports:
//   MEMORY_MASTER_CLOCK_50        in   system clock, rising edge
//   MEMORY_MASTER_ResetInLow_In   in   asynchronous active-low reset
//   MEMORY_MASTER_Req_In          in   request strobe (sampled in IDLE)
//   MEMORY_MASTER_Write_In        in   1 = write, 0 = read
//   MEMORY_MASTER_Addr_InBus      in   access address
//   MEMORY_MASTER_WrData_InBus    in   write data
//   MEMORY_MASTER_Busy_Out        out  high in ACCESS/COMPLETE/ERROR
//   MEMORY_MASTER_Done_Out        out  one-cycle pulse on completion
//   MEMORY_MASTER_Error_Out       out  one-cycle pulse on timeout
//   MEMORY_MASTER_RdData_OutBus   out  last successfully read word
//   MEMORY_MASTER_A_OutBus        out  address to memory
//   MEMORY_MASTER_B_OutBus        out  write data to memory
//   MEMORY_MASTER_RD_Out          out  read strobe to memory
//   MEMORY_MASTER_WRMain_Out      out  write strobe to memory
//   MEMORY_MASTER_ACK_In          in   memory acknowledge
//   MEMORY_MASTER_Data_InBus      in   read data from memory
module memory_master #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     MEMORY_MASTER_CLOCK_50,
  input  logic                     MEMORY_MASTER_ResetInLow_In,
  input  logic                     MEMORY_MASTER_Req_In,
  input  logic                     MEMORY_MASTER_Write_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_WrData_InBus,
  output logic                     MEMORY_MASTER_Busy_Out,
  output logic                     MEMORY_MASTER_Done_Out,
  output logic                     MEMORY_MASTER_Error_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_RdData_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_B_OutBus,
  output logic                     MEMORY_MASTER_RD_Out,
  output logic                     MEMORY_MASTER_WRMain_Out,
  input  logic                     MEMORY_MASTER_ACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_Data_InBus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [DATAWIDTH_BUS-1:0] a_q, a_d;
  logic [DATAWIDTH_BUS-1:0] b_q, b_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;

`ifdef MEMORY_MASTER_TIMEOUT_EN
  // Last counter value still allowed in ACCESS; ACCESS lasts ACK_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
`ifdef MEMORY_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (MEMORY_MASTER_Req_In) begin
          a_d     = MEMORY_MASTER_Addr_InBus;
          // B keeps the last written word across reads.
          if (MEMORY_MASTER_Write_In) b_d = MEMORY_MASTER_WrData_InBus;
          write_d = MEMORY_MASTER_Write_In;
`ifdef MEMORY_MASTER_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (MEMORY_MASTER_ACK_In) begin
          if (!write_q) rdata_d = MEMORY_MASTER_Data_InBus;
          state_d = S_COMPLETE;
        end
`ifdef MEMORY_MASTER_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_COMPLETE: state_d = S_IDLE;
      S_ERROR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Status and strobes are decoded from the next state so that every output
  // comes straight from a flop.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_COMPLETE);
    rd_d   = (state_d == S_ACCESS) && !write_d;
    wr_d   = (state_d == S_ACCESS) &&  write_d;
`ifdef MEMORY_MASTER_TIMEOUT_EN
    err_d  = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge MEMORY_MASTER_CLOCK_50 or negedge MEMORY_MASTER_ResetInLow_In) begin
    if (!MEMORY_MASTER_ResetInLow_In) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEMORY_MASTER_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef MEMORY_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign MEMORY_MASTER_Busy_Out      = busy_q;
  assign MEMORY_MASTER_Done_Out      = done_q;
  assign MEMORY_MASTER_RdData_OutBus = rdata_q;
  assign MEMORY_MASTER_A_OutBus      = a_q;
  assign MEMORY_MASTER_B_OutBus      = b_q;
  assign MEMORY_MASTER_RD_Out        = rd_q;
  assign MEMORY_MASTER_WRMain_Out    = wr_q;
`ifdef MEMORY_MASTER_TIMEOUT_EN
  assign MEMORY_MASTER_Error_Out     = err_q;
`else
  assign MEMORY_MASTER_Error_Out     = 1'b0;
`endif

endmodule

// File: tb/tb_memory_master.sv
module tb_memory_master;

  localparam int W   = 32;
  localparam int TMO = 4;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         write;
  logic [W-1:0] addr;
  logic [W-1:0] wrdata;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] rddata;
  logic [W-1:0] a_bus;
  logic [W-1:0] b_bus;
  logic         rd;
  logic         wrmain;
  logic         ack;
  logic [W-1:0] mem_data;

  memory_master #(
    .DATAWIDTH_BUS(W),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .MEMORY_MASTER_CLOCK_50      (clk),
    .MEMORY_MASTER_ResetInLow_In (rst_n),
    .MEMORY_MASTER_Req_In        (req),
    .MEMORY_MASTER_Write_In      (write),
    .MEMORY_MASTER_Addr_InBus    (addr),
    .MEMORY_MASTER_WrData_InBus  (wrdata),
    .MEMORY_MASTER_Busy_Out      (busy),
    .MEMORY_MASTER_Done_Out      (done),
    .MEMORY_MASTER_Error_Out     (err),
    .MEMORY_MASTER_RdData_OutBus (rddata),
    .MEMORY_MASTER_A_OutBus      (a_bus),
    .MEMORY_MASTER_B_OutBus      (b_bus),
    .MEMORY_MASTER_RD_Out        (rd),
    .MEMORY_MASTER_WRMain_Out    (wrmain),
    .MEMORY_MASTER_ACK_In        (ack),
    .MEMORY_MASTER_Data_InBus    (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  // Expected state of the memory-side buses at each Done pulse.
  typedef struct {
    logic [W-1:0] rd;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] model_rd = '0;
  logic [W-1:0] model_a  = '0;
  logic [W-1:0] model_b  = '0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard side: every Done pulse must match the oldest pending access.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 with no access pending, expected Done=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_rddata", rddata, e.rd);
        check("done_a", a_bus, e.a);
        check("done_b", b_bus, e.b);
      end
    end
    if (rst_n && err) err_seen++;
  end

  // One access with ACK tied high; called at a negedge (cycle 0).
  task automatic do_access(input bit wr, input logic [W-1:0] ad, input logic [W-1:0] wd,
                           input logic [W-1:0] md, input logic [W-1:0] exp_rd);
    req = 1'b1; write = wr; addr = ad; wrdata = wd; mem_data = md; ack = 1'b1;
    model_a = ad;
    if (wr) model_b = wd;
    model_rd = exp_rd;
    sb.push_back('{exp_rd, model_a, model_b});
    step();
    check("c1_rd", {31'd0, rd}, {31'd0, !wr});
    check("c1_wrmain", {31'd0, wrmain}, {31'd0, wr});
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_a", a_bus, model_a);
    check("c1_b", b_bus, model_b);
    req = 1'b0; addr = ~ad; wrdata = ~wd;
    step();
    check("c2_done", {31'd0, done}, 32'd1);
    check("c2_strobes", {30'd0, rd, wrmain}, 32'd0);
    check("c2_busy", {31'd0, busy}, 32'd1);
    step();
    check("c3_busy", {31'd0, busy}, 32'd0);
    check("c3_done", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    bit           wr;
    logic [W-1:0] ad;
    logic [W-1:0] wd;
    logic [W-1:0] md;
    logic [W-1:0] exp_rd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   rd_cnt;

    vecs[0] = '{1'b0, 32'd6,          32'h0,        32'h12BFFFFC, 32'h12BFFFFC};
    vecs[1] = '{1'b1, 32'd3,          32'hDEADBEEF, 32'h55555555, 32'h12BFFFFC};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'h11111111, 32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 32'h00000000,   32'hFFFFFFFF, 32'h0000AAAA, 32'h00000000};
    vecs[4] = '{1'b0, 32'h80000000,   32'h22222222, 32'hA5A55A5A, 32'hA5A55A5A};

    rst_n = 1'b0; req = 1'b0; write = 1'b0; addr = '0; wrdata = '0;
    ack = 1'b0; mem_data = '0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_wrmain", {31'd0, wrmain}, 32'd0);
    check("rst_rddata", rddata, 32'd0);
    check("rst_a", a_bus, 32'd0);
    check("rst_b", b_bus, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      do_access(vecs[i].wr, vecs[i].ad, vecs[i].wd, vecs[i].md, vecs[i].exp_rd);

`ifdef MEMORY_MASTER_TIMEOUT_EN
    // Read that never gets ACK: TMO cycles of ACCESS, then one ERROR cycle.
    req = 1'b1; write = 1'b0; addr = 32'h44; ack = 1'b0; mem_data = 32'hBADBAD00;
    model_a = 32'h44;
    rd_cnt = 0;
    for (int c = 1; c <= TMO; c++) begin
      step();
      req = 1'b0;
      if (rd) rd_cnt++;
    end
    check("tmo_rd_cycles", rd_cnt, TMO);
    step();
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_rd_off", {31'd0, rd}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd1);
    check("tmo_done", {31'd0, done}, 32'd0);
    step();
    check("tmo_idle_busy", {31'd0, busy}, 32'd0);
    check("tmo_idle_err", {31'd0, err}, 32'd0);
    check("tmo_rddata_kept", rddata, model_rd);
`else
    // Slow memory: ACK low for 20 ACCESS cycles, raised in the 21st.
    req = 1'b1; write = 1'b0; addr = 32'd0; ack = 1'b0; mem_data = 32'h9080200A;
    model_a = 32'd0; model_rd = 32'h9080200A;
    sb.push_back('{model_rd, model_a, model_b});
    rd_cnt = 0;
    for (int c = 1; c <= 21; c++) begin
      step();
      req = 1'b0;
      if (rd) rd_cnt++;
      if (c == 21) ack = 1'b1;
    end
    check("slow_rd_cycles", rd_cnt, 21);
    step();
    check("slow_done", {31'd0, done}, 32'd1);
    check("slow_err", {31'd0, err}, 32'd0);
    step();
    check("slow_idle_busy", {31'd0, busy}, 32'd0);
`endif

    // Req held high with the address changing every cycle: accepts at
    // edges 0, 3 and 6 only.
    req = 1'b1; write = 1'b0; ack = 1'b1;
    addr = 32'h100; mem_data = 32'h70000000;
    model_a = 32'h100; model_rd = 32'h70000001;
    sb.push_back('{model_rd, model_a, model_b});
    for (int c = 1; c <= 9; c++) begin
      step();
      check("rep_busy", {31'd0, busy}, {31'd0, (c % 3) != 0});
      check("rep_rd", {31'd0, rd}, {31'd0, (c % 3) == 1});
      check("rep_a", a_bus, 32'h100 + 32'(3 * ((c - 1) / 3)));
      if (c == 9) begin
        req = 1'b0;
      end else begin
        addr = 32'h100 + 32'(c);
        mem_data = 32'h70000000 + 32'(c);
        if (c % 3 == 0) begin
          model_a = addr; model_rd = 32'h70000000 + 32'(c + 1);
          sb.push_back('{model_rd, model_a, model_b});
        end
      end
    end

    // Reset asserted mid-way through cycle 1 of a write.
    req = 1'b1; write = 1'b1; addr = 32'h55; wrdata = 32'h1234; ack = 1'b0;
    step();
    check("rw_wrmain_c1", {31'd0, wrmain}, 32'd1);
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_wrmain", {31'd0, wrmain}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_a", a_bus, 32'd0);
    check("rw_b", b_bus, 32'd0);
    check("rw_rddata", rddata, 32'd0);
    step();
    rst_n = 1'b1; ack = 1'b1;
    model_a = '0; model_b = '0; model_rd = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rw_post_status", {29'd0, busy, done, err}, 32'd0);
    end
    do_access(1'b0, 32'd9, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);

`ifdef MEMORY_MASTER_TIMEOUT_EN
    check("error_pulses", err_seen, 1);
`else
    check("error_pulses", err_seen, 0);
`endif
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_master.md
# memory_master

Bus initiator that connects the datapath control unit to main memory. It accepts single read or write requests, drives address, write data and the RD/WRMain strobes toward memory, and waits for the memory ACK. On a read it latches the returned word, then reports completion to the requester with a one-cycle pulse. It is the requesting end of the memory's A/B/RD/WRMain/ACK interface and sits between the control unit and the main memory inside the datapath.

## Interface
- DATAWIDTH_BUS, 32, width of address, write-data and read-data buses
- ACK_TIMEOUT, 15, number of ACCESS cycles without ACK before an access is aborted; legal range 1..255 (8-bit counter)

- MEMORY_MASTER_CLOCK_50  in  1  system clock, rising edge
- MEMORY_MASTER_ResetInLow_In  in  1  asynchronous, active-low reset
- MEMORY_MASTER_Req_In  in  1  request strobe, sampled only in IDLE
- MEMORY_MASTER_Write_In  in  1  1 = write, 0 = read; sampled with Req
- MEMORY_MASTER_Addr_InBus  in  DATAWIDTH_BUS  access address; sampled with Req
- MEMORY_MASTER_WrData_InBus  in  DATAWIDTH_BUS  write data; sampled with Req
- MEMORY_MASTER_Busy_Out  out  1  high in ACCESS, COMPLETE and ERROR
- MEMORY_MASTER_Done_Out  out  1  one-cycle pulse on successful completion
- MEMORY_MASTER_Error_Out  out  1  one-cycle pulse on timeout
- MEMORY_MASTER_RdData_OutBus  out  DATAWIDTH_BUS  last successfully read word
- MEMORY_MASTER_A_OutBus  out  DATAWIDTH_BUS  address to memory
- MEMORY_MASTER_B_OutBus  out  DATAWIDTH_BUS  write data to memory
- MEMORY_MASTER_RD_Out  out  1  read strobe to memory
- MEMORY_MASTER_WRMain_Out  out  1  write strobe to memory
- MEMORY_MASTER_ACK_In  in  1  memory acknowledge
- MEMORY_MASTER_Data_InBus  in  DATAWIDTH_BUS  read data from memory

## Operation
- States: IDLE, ACCESS, COMPLETE, ERROR. All outputs are registered.
- IDLE: when Req=1 at the clock edge, register Addr into A_OutBus, register WrData into B_OutBus (writes only; B_OutBus holds its value on reads), capture Write, clear the timeout counter, and go to ACCESS.
- ACCESS: RD_Out=~Write and WRMain_Out=Write. A/B are held stable.
  - ACK=1 at the edge: on a read, latch Data_InBus into RdData_OutBus; go to COMPLETE.
  - ACK=0 and counter==ACK_TIMEOUT-1: go to ERROR.
  - Otherwise: increment the counter.
- COMPLETE: Done_Out=1, strobes 0; go to IDLE.
- ERROR: Error_Out=1, strobes 0, RdData unchanged; go to IDLE.
- Req outside IDLE is ignored. There is no queueing. A Req still held high in COMPLETE or ERROR is accepted in the following IDLE cycle.
- A_OutBus and B_OutBus hold their last values after an access. RD and WRMain are 0 in every state other than ACCESS.
- Reset (asynchronous): state IDLE; all outputs 0, including both strobes, Busy, Done, Error, RdData, A and B. A reset during ACCESS drops the strobes immediately and discards the access.

## Timing
- Request sampled at edge 0. Cycle 1 is ACCESS with strobes high.
- With ACK already high (memory that acknowledges combinationally): cycle 2 is COMPLETE with Done=1 and RdData valid; cycle 3 is IDLE. Minimum cycle from accept to Done is 2; throughput is 1 access per 3 cycles.
- Timeout: ACCESS lasts exactly ACK_TIMEOUT cycles, then ERROR for 1 cycle.
- ACK is ignored outside ACCESS.

## Configuration
- MEMORY_MASTER_TIMEOUT_EN defined: the timeout counter and the ERROR state exist, as described above.
- Not defined: no counter. ACCESS waits for ACK indefinitely, Error_Out is tied to 0, and ACK_TIMEOUT is unused.

## Test plan
- Read at Addr=6 with ACK tied 1 and memory returning 0x12BFFFFC -> RD high in cycle 1 only; Done pulse in cycle 2; RdData=0x12BFFFFC; Busy high in cycles 1-2.
- Write Addr=3, WrData=0xDEADBEEF, ACK tied 1 -> WRMain high in cycle 1 only with A=3 and B=0xDEADBEEF; RD stays 0; Done pulse in cycle 2; RdData unchanged.
- TIMEOUT_EN set, ACK_TIMEOUT=4, ACK held 0, read -> RD high in cycles 1-4; Error=1 in cycle 5; Done never asserts; IDLE in cycle 6; RdData keeps its previous value.
- TIMEOUT_EN not set, ACK held 0 for 20 cycles then raised, read Addr=0 with data 0x9080200A -> RD high for 21 cycles; Done pulse on the next cycle; RdData=0x9080200A; Error stays 0.
- Req held high continuously, ACK tied 1 -> accesses accepted every 3 cycles; Req pulses during cycles 1-2 are ignored; Addr changes while Busy do not change A_OutBus.
- Reset asserted in cycle 1 of a write -> WRMain, Busy and all other outputs go to 0 before the next edge; after reset is released, state is IDLE and no Done or Error pulse appears.
